// File: rtl/cam_pixel_capture.sv
// Parallel camera capture front end: pairs bus bytes into RGB565 pixels,
// tracks row/column, generates frame-buffer write addresses and flags geometry errors.
module cam_pixel_capture #(
  parameter int p_width   = 160,
  parameter int p_height  = 120,
  parameter int p_coord_w = 10,
  parameter int p_addr_w  = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_vsync,
  input  logic                 i_href,
  input  logic [7:0]           i_data,
  input  logic                 i_enable,
  output logic                 o_valid,
  output logic [15:0]          o_data,
  output logic [p_coord_w-1:0] o_row,
  output logic [p_coord_w-1:0] o_col,
  output logic [p_addr_w-1:0]  o_addr,
  output logic                 o_frame_start,
  output logic                 o_frame_done,
  output logic [7:0]           o_frame_count,
  output logic                 o_err_line_len,
  output logic                 o_err_line_cnt
);

  localparam logic [1:0] st_sync   = 2'd0;
  localparam logic [1:0] st_wait   = 2'd1;
  localparam logic [1:0] st_skip   = 2'd2;
  localparam logic [1:0] st_active = 2'd3;

  localparam int c_bcnt_w = $clog2(2 * p_width + 2) + 1;

  localparam logic [p_coord_w-1:0] c_width      = p_coord_w'(p_width);
  localparam logic [p_coord_w-1:0] c_height     = p_coord_w'(p_height);
  localparam logic [p_addr_w-1:0]  c_width_a    = p_addr_w'(p_width);
  localparam logic [c_bcnt_w-1:0]  c_line_bytes = c_bcnt_w'(2 * p_width);

  logic                 vsync_r, href_r, enable_r;
  logic [7:0]           data_r;
  logic                 vsync_d, href_d;
  logic [1:0]           state;
  logic                 seen_high;
  logic                 phase;
  logic [7:0]           hi_byte;
  logic [c_bcnt_w-1:0]  byte_cnt;
  logic [p_coord_w-1:0] col, row;
  logic [p_addr_w-1:0]  addr, line_base;

  logic                 href_rise, vsync_rise, line_end, pix_ok, line_len_bad;
  logic [p_coord_w-1:0] row_inc, col_inc, row_final;
  logic [c_bcnt_w-1:0]  bcnt_inc;

  assign href_rise    = href_r & ~href_d;
  assign vsync_rise   = vsync_r & ~vsync_d;
  // A vsync rise while a line is open closes that line in the same cycle.
  assign line_end     = href_d & (~href_r | vsync_rise);
  assign row_inc      = (row == '1) ? row : row + p_coord_w'(1);
  assign col_inc      = (col == '1) ? col : col + p_coord_w'(1);
  assign bcnt_inc     = (byte_cnt == '1) ? byte_cnt : byte_cnt + c_bcnt_w'(1);
  assign row_final    = line_end ? row_inc : row;
  assign pix_ok       = (col < c_width) && (row < c_height);
  assign line_len_bad = (byte_cnt != c_line_bytes) | phase;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vsync_r        <= 1'b0;
      href_r         <= 1'b0;
      enable_r       <= 1'b0;
      data_r         <= '0;
      vsync_d        <= 1'b0;
      href_d         <= 1'b0;
      state          <= st_sync;
      seen_high      <= 1'b0;
      phase          <= 1'b0;
      hi_byte        <= '0;
      byte_cnt       <= '0;
      col            <= '0;
      row            <= '0;
      addr           <= '0;
      line_base      <= '0;
      o_valid        <= 1'b0;
      o_data         <= '0;
      o_row          <= '0;
      o_col          <= '0;
      o_addr         <= '0;
      o_frame_start  <= 1'b0;
      o_frame_done   <= 1'b0;
      o_frame_count  <= '0;
      o_err_line_len <= 1'b0;
      o_err_line_cnt <= 1'b0;
    end else begin
      vsync_r       <= i_vsync;
      href_r        <= i_href;
      enable_r      <= i_enable;
      data_r        <= i_data;
      vsync_d       <= vsync_r;
      href_d        <= href_r;
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;

      case (state)
        st_sync: begin
          if (vsync_r) begin
            seen_high <= 1'b1;
          end else if (seen_high) begin
            seen_high <= 1'b0;
            state     <= st_wait;
          end
        end

        st_wait: begin
          if (vsync_r) begin
            seen_high <= 1'b1;
            state     <= st_sync;
          end else if (href_rise) begin
            if (enable_r) begin
              state          <= st_active;
              o_frame_start  <= 1'b1;
              o_err_line_len <= 1'b0;
              o_err_line_cnt <= 1'b0;
              o_row          <= '0;
              o_col          <= '0;
              o_addr         <= '0;
              row            <= '0;
              col            <= '0;
              addr           <= '0;
              line_base      <= '0;
              hi_byte        <= data_r;
              phase          <= 1'b1;
              byte_cnt       <= c_bcnt_w'(1);
            end else begin
              state <= st_skip;
            end
          end
        end

        st_skip: begin
          if (vsync_rise) begin
            seen_high <= 1'b1;
            state     <= st_sync;
          end
        end

        st_active: begin
          if (line_end) begin
            if (line_len_bad) o_err_line_len <= 1'b1;
            col      <= '0;
            row      <= row_inc;
            phase    <= 1'b0;
            byte_cnt <= '0;
            // Re-base from the row start so short or long lines never skew later rows.
            if (row < c_height) begin
              line_base <= line_base + c_width_a;
              addr      <= line_base + c_width_a;
            end
          end

          if (vsync_rise) begin
            o_frame_done  <= 1'b1;
            o_frame_count <= o_frame_count + 8'd1;
            if (row_final != c_height) o_err_line_cnt <= 1'b1;
            seen_high     <= 1'b1;
            state         <= st_sync;
          end else if (href_r) begin
            if (href_rise || !phase) begin
              hi_byte  <= data_r;
              phase    <= 1'b1;
              byte_cnt <= href_rise ? c_bcnt_w'(1) : bcnt_inc;
            end else begin
              phase    <= 1'b0;
              byte_cnt <= bcnt_inc;
              col      <= col_inc;
              if (pix_ok) begin
                o_valid <= 1'b1;
                o_data  <= {hi_byte, data_r};
                o_row   <= row;
                o_col   <= col;
                o_addr  <= addr;
                addr    <= addr + p_addr_w'(1);
              end
            end
          end
        end

        default: state <= st_sync;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Self-checking bench for cam_pixel_capture: table of frame scenarios plus
// reset and counter-wrap sequences, with a pixel scoreboard checking every o_valid.
module tb_cam_pixel_capture;

  localparam int W = 12;
  localparam int H = 6;

  logic       i_clk;
  logic       i_rst;
  logic       i_vsync;
  logic       i_href;
  logic [7:0] i_data;
  logic       i_enable;
  logic       o_valid;
  logic [15:0] o_data;
  logic [9:0] o_row;
  logic [9:0] o_col;
  logic [6:0] o_addr;
  logic       o_frame_start;
  logic       o_frame_done;
  logic [7:0] o_frame_count;
  logic       o_err_line_len;
  logic       o_err_line_cnt;

  cam_pixel_capture #(
    .p_width  (W),
    .p_height (H),
    .p_coord_w(10),
    .p_addr_w (7)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_vsync       (i_vsync),
    .i_href        (i_href),
    .i_data        (i_data),
    .i_enable      (i_enable),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .o_row         (o_row),
    .o_col         (o_col),
    .o_addr        (o_addr),
    .o_frame_start (o_frame_start),
    .o_frame_done  (o_frame_done),
    .o_frame_count (o_frame_count),
    .o_err_line_len(o_err_line_len),
    .o_err_line_cnt(o_err_line_cnt)
  );

  typedef struct {
    logic [15:0] data;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [6:0]  addr;
    int          cyc;
  } pix_t;

  typedef struct {
    bit         en;
    int         drop_line;
    int         nlines;
    int         sp_line;
    int         sp_len;
    int         exp_valid;
    bit         exp_err_len;
    bit         exp_err_cnt;
    logic [7:0] exp_count;
  } vec_t;

  pix_t sb[$];
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   valid_cnt = 0;
  int   start_cnt = 0;
  int   done_cnt  = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    pix_t e;
    forever begin
      @(negedge i_clk);
      if (o_valid) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got pixel 0x%0h at addr %0d, required no pixel", o_data, o_addr);
        end else begin
          e = sb.pop_front();
          check("pixel", 128'({o_data, o_row, o_col, o_addr}), 128'({e.data, e.row, e.col, e.addr}));
          check("pixel_latency", 128'(cyc), 128'(e.cyc));
        end
      end
      if (o_frame_start) start_cnt++;
      if (o_frame_done) done_cnt++;
      if (o_frame_start || o_frame_done)
        check("start_done_overlap", 128'(o_frame_start & o_frame_done), 128'(0));
    end
  endtask

  task automatic drive_line(input int line, input int len, input bit cap);
    logic [7:0] hi;
    logic [7:0] lo;
    pix_t e;
    hi = '0;
    for (int b = 0; b < len; b++) begin
      @(negedge i_clk);
      i_href = 1'b1;
      if (b % 2 == 0) begin
        hi = 8'h5A ^ 8'(line * 16 + b / 2);
        i_data = hi;
      end else begin
        lo = 8'hC3 ^ 8'(b);
        i_data = lo;
        if (cap && line < H && b / 2 < W) begin
          e.data = {hi, lo};
          e.row  = 10'(line);
          e.col  = 10'(b / 2);
          e.addr = 7'(line * W + b / 2);
          e.cyc  = cyc + 2;
          sb.push_back(e);
        end
      end
    end
    repeat (6) begin
      @(negedge i_clk);
      i_href = 1'b0;
      i_data = 8'($urandom);
    end
  endtask

  task automatic vsync_pulse();
    repeat (4) begin
      @(negedge i_clk);
      i_vsync = 1'b1;
    end
    repeat (4) begin
      @(negedge i_clk);
      i_vsync = 1'b0;
    end
  endtask

  initial begin
    vec_t v;
    int   v0, s0, d0, len;

    //         en drop lines sp  splen valid elen ecnt count
    vecs[0] = '{1, -1, 6, -1, 0,  72, 0, 0, 8'd1};  // nominal
    vecs[1] = '{1, -1, 6,  3, 22, 71, 1, 0, 8'd2};  // short line
    vecs[2] = '{1, -1, 8,  0, 30, 72, 1, 1, 8'd3};  // long line, extra lines
    vecs[3] = '{1, -1, 6,  2, 25, 72, 1, 0, 8'd4};  // odd byte count
    vecs[4] = '{1,  2, 6, -1, 0,  72, 0, 0, 8'd5};  // enable dropped mid-frame
    vecs[5] = '{0, -1, 6, -1, 0,  0,  0, 0, 8'd5};  // skipped frame
    vecs[6] = '{1, -1, 5,  4, 20, 58, 1, 1, 8'd6};  // short line, too few lines

    i_rst = 1'b1; i_vsync = 1'b0; i_href = 1'b0; i_data = '0; i_enable = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(negedge i_clk);
    check("reset_state", 128'({o_valid, o_data, o_row, o_col, o_addr, o_frame_start, o_frame_done,
                               o_frame_count, o_err_line_len, o_err_line_cnt}), 128'(0));
    i_rst = 1'b0;
    vsync_pulse();

    for (int r = 0; r < 7; r++) begin
      v = vecs[r];
      i_enable = v.en;
      v0 = valid_cnt; s0 = start_cnt; d0 = done_cnt;
      for (int l = 0; l < v.nlines; l++) begin
        if (l == v.drop_line) i_enable = 1'b0;
        len = (l == v.sp_line) ? v.sp_len : 2 * W;
        drive_line(l, len, v.en);
        if (l == v.sp_line && v.en) check("err_len_mid_frame", 128'(o_err_line_len), 128'(1));
      end
      vsync_pulse();
      repeat (2) @(negedge i_clk);
      check("valid_count", 128'(valid_cnt - v0), 128'(v.exp_valid));
      check("frame_start_count", 128'(start_cnt - s0), 128'(v.en));
      check("frame_done_count", 128'(done_cnt - d0), 128'(v.en));
      check("frame_count", 128'(o_frame_count), 128'(v.exp_count));
      check("err_line_len", 128'(o_err_line_len), 128'(v.exp_err_len));
      check("err_line_cnt", 128'(o_err_line_cnt), 128'(v.exp_err_cnt));
      check("queue_empty", 128'(sb.size()), 128'(0));
      sb.delete();
    end

    // Reset in the middle of a captured frame.
    i_enable = 1'b1;
    d0 = done_cnt;
    for (int l = 0; l < 3; l++) drive_line(l, 2 * W, 1'b1);
    check("queue_drained_before_reset", 128'(sb.size()), 128'(0));
    sb.delete();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("reset_mid_frame", 128'({o_valid, o_data, o_row, o_col, o_addr, o_frame_start, o_frame_done,
                                   o_frame_count, o_err_line_len, o_err_line_cnt}), 128'(0));
    v0 = valid_cnt;
    for (int l = 3; l < H; l++) drive_line(l, 2 * W, 1'b0);
    check("valid_after_reset", 128'(valid_cnt - v0), 128'(0));
    vsync_pulse();
    v0 = valid_cnt;
    for (int l = 0; l < H; l++) drive_line(l, 2 * W, 1'b1);
    vsync_pulse();
    repeat (2) @(negedge i_clk);
    check("restart_valid_count", 128'(valid_cnt - v0), 128'(H * W));
    check("restart_done_count", 128'(done_cnt - d0), 128'(1));
    check("restart_frame_count", 128'(o_frame_count), 128'(1));
    check("restart_queue_empty", 128'(sb.size()), 128'(0));
    sb.delete();

    // Frame counter wrap using single-line frames.
    for (int f = 0; f < 254; f++) begin
      drive_line(0, 2 * W, 1'b1);
      vsync_pulse();
    end
    repeat (2) @(negedge i_clk);
    check("frame_count_255", 128'(o_frame_count), 128'(255));
    check("err_line_cnt_short_frame", 128'(o_err_line_cnt), 128'(1));
    check("err_line_len_clean", 128'(o_err_line_len), 128'(0));
    drive_line(0, 2 * W, 1'b1);
    vsync_pulse();
    repeat (2) @(negedge i_clk);
    check("frame_count_wrap", 128'(o_frame_count), 128'(0));
    check("wrap_queue_empty", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Capture front end for the OV7670-style parallel camera port, running in the camera pixel-clock domain.
- Pairs the 8-bit bus bytes into RGB565 pixels, tracks row/column, and generates a linear frame-buffer write address.
- Flags frame boundaries and geometry errors.
- Output drives the 160x120 frame-buffer write port and the grayscale/Sobel write-side chain directly.

Parameters:
- p_width, 160, active pixels per line written to the frame buffer
- p_height, 120, active lines per frame written to the frame buffer
- p_coord_w, 10, width of the row/column outputs
- p_addr_w, 15, frame-buffer address width; must satisfy 2^p_addr_w >= p_width*p_height

Ports:
- i_clk  in  1  camera pixel clock
- i_rst  in  1  synchronous reset, active-high
- i_vsync  in  1  camera vsync, high during vertical blanking
- i_href  in  1  camera href, high during active line bytes
- i_data  in  8  camera data byte
- i_enable  in  1  capture enable, sampled only at frame start
- o_valid  out  1  one-cycle pixel strobe
- o_data  out  16  RGB565 pixel, {first byte, second byte}
- o_row  out  p_coord_w  row of o_data
- o_col  out  p_coord_w  column of o_data
- o_addr  out  p_addr_w  row*p_width+col of o_data
- o_frame_start  out  1  one-cycle pulse at the first href of a captured frame
- o_frame_done  out  1  one-cycle pulse at vsync rise ending a captured frame
- o_frame_count  out  8  captured-frame counter, wraps 255->0
- o_err_line_len  out  1  sticky: some line in the current frame had byte count != 2*p_width
- o_err_line_cnt  out  1  sticky: the last completed frame had line count != p_height

Behaviour:
- Reset: all outputs 0; state SYNC; byte phase 0; counters 0. Reset mid-frame discards the partial frame; capture resumes only after a full vsync high->low sequence.
- Inputs are registered once before use. All latencies below are counted from the cycle the byte appears on the registered input.
- State SYNC: wait for vsync high, then vsync low -> WAIT.
- State WAIT (vsync low, before first href):
  - first href rise with i_enable=1 -> ACTIVE and pulse o_frame_start. This pulse clears o_err_line_len and o_err_line_cnt; row, col and addr go to 0.
  - first href rise with i_enable=0 -> SKIP.
- State SKIP: ignore data; vsync rise -> SYNC.
- State ACTIVE:
  - Byte phase toggles each href-high cycle and is forced to 0 at every href rise.
  - Phase 0 byte is latched as the high byte; phase 1 byte completes the pixel.
  - o_valid is asserted the cycle after the phase-1 byte is registered, with o_data/o_row/o_col/o_addr stable in that cycle.
  - col increments after each completed pixel.
  - Pixels with col >= p_width or row >= p_height produce no o_valid and no addr increment; they are still counted for error checking.
  - o_addr is an incrementing counter, not a multiplier; it equals row*p_width+col for every valid pixel.
- href fall in ACTIVE:
  - If byte count != 2*p_width, or phase = 1 (odd byte left over), set o_err_line_len. A dangling high byte is dropped.
  - col <= 0; row increments (saturating at 2^p_coord_w-1).
  - Lines longer than p_width do not advance o_addr past the end of the line.
- vsync rise in ACTIVE:
  - Pulse o_frame_done and increment o_frame_count.
  - If row != p_height, set o_err_line_cnt; it holds until the next o_frame_start.
  - -> WAIT via SYNC rules: vsync low returns to WAIT.
- vsync rise while href is high: treated as href fall then frame end in the same cycle, so both the line check and the frame check apply.
- i_enable deasserted mid-frame: the current frame completes normally; the next frame goes to SKIP.
- o_valid is never asserted outside ACTIVE. o_frame_start and o_frame_done are never asserted in the same cycle.

Test Plan:
- Nominal frame: vsync pulse, 120 lines x 320 bytes, byte pairs 0xAB,0xCD -> 19200 o_valid pulses with o_data=0xABCD; last pixel row=119, col=159, addr=19199; one o_frame_start, one o_frame_done; o_frame_count=1; both error flags 0.
- Short line: line 5 has 318 bytes -> o_err_line_len=1 from that line until the next frame start; row 6 starts at addr=960; 19199 valid pulses total.
- Long line and extra lines: line 0 has 330 bytes and the frame has 122 lines -> no o_valid for col>=160 or row>=120; o_err_line_len=1; o_err_line_cnt=1 after o_frame_done.
- Reset mid-frame: assert i_rst at row 60 -> all outputs 0 next cycle; the remainder of that frame produces no o_valid; capture restarts at addr 0 on the frame after the next vsync.
- Enable gating: i_enable=0 at frame start -> no o_valid or pulses for that frame. Drop i_enable mid-frame -> that frame completes with 19200 pulses and the following frame is skipped.
- Counter wrap: 256 nominal frames -> o_frame_count returns to 0; odd-byte line (321 bytes) sets o_err_line_len and drops the dangling byte.
